// File: rtl/ib_unicast_pkg.sv
// Shared router definitions: port directions, buffer defaults
// and the flit fields that route computation decodes.
package ib_unicast_pkg;

  localparam int IB_DEPTH    = 4;
  localparam int IB_WIDTH    = 2;
  localparam int IB_DATASIZE = 30;

  localparam logic [4:0] DIR_N = 5'b00001;
  localparam logic [4:0] DIR_E = 5'b00010;
  localparam logic [4:0] DIR_W = 5'b00100;
  localparam logic [4:0] DIR_S = 5'b01000;
  localparam logic [4:0] DIR_L = 5'b10000;

  // Destination ID sits in the low bits: X then Y coordinate
  localparam int DST_X_LSB = 0;
  localparam int DST_X_MSB = 1;
  localparam int DST_Y_LSB = 2;
  localparam int DST_Y_MSB = 3;

  function automatic logic [3:0] flit_dst(
    input logic [IB_DATASIZE-1:0] flit
  );
    return flit[DST_Y_MSB:DST_X_LSB];
  endfunction

endpackage

// File: rtl/ib_unicast_mem.sv
// Flit storage: DEPTH x DATASIZE registers, one write port
// and one asynchronous read port, cleared by reset.
module ib_unicast_mem #(
  parameter int DEPTH    = 4,
  parameter int WIDTH    = 2,
  parameter int DATASIZE = 30
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                we_i,
  input  logic [WIDTH-1:0]    waddr_i,
  input  logic [DATASIZE-1:0] wdata_i,
  input  logic [WIDTH-1:0]    raddr_i,
  output logic [DATASIZE-1:0] rdata_o
);

  logic [DATASIZE-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ib_unicast.sv
// Per-input-port fall-through flit buffer with credit return
// toward the upstream link.
module ib_unicast
  import ib_unicast_pkg::*;
#(
  parameter int DEPTH    = IB_DEPTH,
  parameter int WIDTH    = IB_WIDTH,
  parameter int DATASIZE = IB_DATASIZE
) (
  input  logic                ib_clk,
  input  logic                rst,
  input  logic [DATASIZE-1:0] data_in,
  input  logic                valid_in,
  output logic [DATASIZE-1:0] data_out,
  output logic                valid_out,
  input  logic                rc_ready,
  output logic                credit_out,
  output logic                full,
  output logic                empty,
  output logic [WIDTH:0]      count,
  output logic                overflow_err
);

  localparam logic [WIDTH:0] FULL_CNT = (WIDTH+1)'(DEPTH);

  logic [WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             credit_q;
  logic             push_acc, pop_acc;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign pop_acc   = rc_ready && !empty;
  // A pop in the same cycle frees the slot a full-buffer push needs
  assign push_acc  = valid_in && (!full || pop_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q + WIDTH'(push_acc);
    rd_ptr_d = rd_ptr_q + WIDTH'(pop_acc);
    count_d  = count_q + (WIDTH+1)'(push_acc)
                       - (WIDTH+1)'(pop_acc);
    ovf_d    = ovf_q | (valid_in & full & ~pop_acc);
  end

  always_ff @(posedge ib_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      credit_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      credit_q <= pop_acc;
    end
  end

  ib_unicast_mem #(
    .DEPTH    (DEPTH),
    .WIDTH    (WIDTH),
    .DATASIZE (DATASIZE)
  ) u_mem (
    .clk_i   (ib_clk),
    .rst_i   (rst),
    .we_i    (push_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (data_out)
  );

  assign valid_out    = !empty;
  assign credit_out   = credit_q;
  assign count        = count_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_ib_unicast.sv
// Directed bench for the unicast input buffer: fill, drain,
// overflow, full push/pop, streaming and mid-stream reset.
module tb_ib_unicast;

  localparam int DS = 30;

  logic          ib_clk = 1'b0;
  logic          rst = 1'b1;
  logic [DS-1:0] data_in = '0;
  logic          valid_in = 1'b0;
  logic          rc_ready = 1'b0;
  logic [DS-1:0] data_out;
  logic          valid_out;
  logic          credit_out;
  logic          full;
  logic          empty;
  logic [2:0]    count;
  logic          overflow_err;

  int errors = 0;
  int checks = 0;

  ib_unicast #(.DEPTH(4), .WIDTH(2), .DATASIZE(DS)) dut (
    .ib_clk       (ib_clk),
    .rst          (rst),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .rc_ready     (rc_ready),
    .credit_out   (credit_out),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow_err (overflow_err)
  );

  always #5 ib_clk = ~ib_clk;

  task automatic step();
    @(posedge ib_clk);
    #1;
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    rc_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic fill4();
    for (int i = 1; i <= 4; i++) begin
      valid_in = 1'b1;
      data_in  = DS'(i);
      step();
    end
    valid_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (valid_out !== 1'b0 || data_out !== '0 || credit_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: valid=%b data=%h credit=%b want 0 0 0",
               valid_out, data_out, credit_out);
    end
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || count !== 3'd0 ||
        overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: empty=%b full=%b count=%0d ovf=%b want 1 0 0 0",
               empty, full, count, overflow_err);
    end
  endtask

  task automatic test_first_push();
    do_reset();
    valid_in = 1'b1;
    data_in  = 30'h00000A1;
    step();
    valid_in = 1'b0;
    checks++;
    if (valid_out !== 1'b1 || data_out !== 30'h00000A1) begin
      errors++;
      $display("FAIL first_head: valid=%b data=%h want 1 0a1",
               valid_out, data_out);
    end
    checks++;
    if (count !== 3'd1 || empty !== 1'b0 || credit_out !== 1'b0) begin
      errors++;
      $display("FAIL first_flags: count=%0d empty=%b credit=%b want 1 0 0",
               count, empty, credit_out);
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    fill4();
    checks++;
    if (full !== 1'b1 || count !== 3'd4) begin
      errors++;
      $display("FAIL fill: full=%b count=%0d want 1 4", full, count);
    end
    rc_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (data_out !== DS'(i) || valid_out !== 1'b1) begin
        errors++;
        $display("FAIL drain_head%0d: data=%h valid=%b want %h 1",
                 i, data_out, valid_out, DS'(i));
      end
      step();
      checks++;
      if (credit_out !== 1'b1) begin
        errors++;
        $display("FAIL drain_credit%0d: got %b want 1", i, credit_out);
      end
    end
    checks++;
    if (empty !== 1'b1 || count !== 3'd0) begin
      errors++;
      $display("FAIL drain_empty: empty=%b count=%0d want 1 0", empty, count);
    end
    step();
    rc_ready = 1'b0;
    checks++;
    if (credit_out !== 1'b0) begin
      errors++;
      $display("FAIL idle_credit: got %b want 0", credit_out);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    fill4();
    valid_in = 1'b1;
    data_in  = 30'h5;
    step();
    valid_in = 1'b0;
    checks++;
    if (overflow_err !== 1'b1 || count !== 3'd4) begin
      errors++;
      $display("FAIL ovf_flag: ovf=%b count=%0d want 1 4", overflow_err, count);
    end
    rc_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (data_out !== DS'(i)) begin
        errors++;
        $display("FAIL ovf_drain%0d: got %h want %h", i, data_out, DS'(i));
      end
      step();
    end
    rc_ready = 1'b0;
    checks++;
    if (empty !== 1'b1 || valid_out !== 1'b0 || overflow_err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_end: empty=%b valid=%b ovf=%b want 1 0 1",
               empty, valid_out, overflow_err);
    end
    step();
    checks++;
    if (overflow_err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b want 1", overflow_err);
    end
  endtask

  task automatic test_full_pushpop();
    logic [DS-1:0] exp [4];
    exp[0] = 30'h2; exp[1] = 30'h3; exp[2] = 30'h4; exp[3] = 30'h6;
    do_reset();
    fill4();
    valid_in = 1'b1;
    data_in  = 30'h6;
    rc_ready = 1'b1;
    checks++;
    if (data_out !== 30'h1) begin
      errors++;
      $display("FAIL fpp_head: got %h want 1", data_out);
    end
    step();
    valid_in = 1'b0;
    checks++;
    if (count !== 3'd4 || overflow_err !== 1'b0 || credit_out !== 1'b1) begin
      errors++;
      $display("FAIL fpp_flags: count=%0d ovf=%b credit=%b want 4 0 1",
               count, overflow_err, credit_out);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (data_out !== exp[i]) begin
        errors++;
        $display("FAIL fpp_order%0d: got %h want %h", i, data_out, exp[i]);
      end
      step();
    end
    rc_ready = 1'b0;
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL fpp_empty: got %b want 1", empty);
    end
  endtask

  task automatic test_stream();
    do_reset();
    valid_in = 1'b1;
    rc_ready = 1'b1;
    data_in  = 30'h10;
    step();
    for (int i = 1; i <= 10; i++) begin
      if (i == 10) valid_in = 1'b0;
      data_in = DS'(16 + i);
      checks++;
      if (data_out !== DS'(15 + i) || valid_out !== 1'b1) begin
        errors++;
        $display("FAIL stream_head%0d: data=%h valid=%b want %h 1",
                 i, data_out, valid_out, DS'(15 + i));
      end
      checks++;
      if (count > 3'd1) begin
        errors++;
        $display("FAIL stream_count%0d: got %0d want <=1", i, count);
      end
      step();
      checks++;
      if (credit_out !== 1'b1) begin
        errors++;
        $display("FAIL stream_credit%0d: got %b want 1", i, credit_out);
      end
    end
    rc_ready = 1'b0;
    checks++;
    if (empty !== 1'b1 || count !== 3'd0) begin
      errors++;
      $display("FAIL stream_end: empty=%b count=%0d want 1 0", empty, count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fill4();
    rc_ready = 1'b1;
    step();
    rc_ready = 1'b0;
    checks++;
    if (count !== 3'd3 || credit_out !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: count=%0d credit=%b want 3 1", count, credit_out);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (valid_out !== 1'b0 || data_out !== '0 || credit_out !== 1'b0 ||
        count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL mid_async: valid=%b data=%h credit=%b count=%0d empty=%b full=%b",
               valid_out, data_out, credit_out, count, empty, full);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (credit_out !== 1'b0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_nocredit: credit=%b valid=%b want 0 0",
               credit_out, valid_out);
    end
    valid_in = 1'b1;
    data_in  = 30'h7;
    step();
    valid_in = 1'b0;
    checks++;
    if (data_out !== 30'h7 || count !== 3'd1 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL mid_after: data=%h count=%0d valid=%b want 7 1 1",
               data_out, count, valid_out);
    end
  endtask

  initial begin
    test_reset();
    test_first_push();
    test_fill_drain();
    test_overflow();
    test_full_pushpop();
    test_stream();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ib_unicast.md
Name: ib_unicast

Overview:
- Per-input-port flit buffer for the unicast baseline router. It sits directly upstream of the route-computation stage.
- It accepts flits from the link (or from the local port), stores up to DEPTH of them, and presents the head flit with a valid to route computation.
- It returns one credit upstream for every flit popped. The router top instantiates five of these, one each for N, E, W, S and L.

Parameters:
- DEPTH, 4, number of flit slots; must be a power of 2.
- WIDTH, 2, pointer width; must equal log2(DEPTH).
- DATASIZE, 30, flit width in bits.

Ports:
- ib_clk  input  1  buffer clock (same clock domain as rc_clk)
- rst  input  1  asynchronous, active-high reset
- data_in  input  DATASIZE  flit from upstream link
- valid_in  input  1  data_in valid; a push request
- data_out  output  DATASIZE  head flit; drives route computation data_in
- valid_out  output  1  buffer non-empty; drives route computation valid_in
- rc_ready  input  1  route computation consumes the head flit this cycle; a pop request
- credit_out  output  1  one-cycle pulse returning one credit upstream
- full  output  1  occupancy == DEPTH
- empty  output  1  occupancy == 0
- count  output  WIDTH+1  current occupancy, 0..DEPTH
- overflow_err  output  1  sticky protocol-error flag

Behaviour:
- Reset (rst=1, asynchronous, takes effect immediately):
  - wr_ptr=0, rd_ptr=0, count=0.
  - All storage slots cleared to 0.
  - valid_out=0, data_out=0, credit_out=0, overflow_err=0, empty=1, full=0.
- Reset asserted mid-operation:
  - All stored flits are discarded.
  - No credit pulse is produced for the discarded flits.
  - Upstream resets its credit counter by the same reset.
- Push:
  - valid_in=1 at a rising edge writes data_in to slot wr_ptr.
  - wr_ptr increments modulo DEPTH, so it wraps from DEPTH-1 to 0.
- Pop:
  - valid_out=1 and rc_ready=1 at a rising edge advances rd_ptr modulo DEPTH.
  - rc_ready while empty is ignored: no pointer change, no credit.
- Head presentation (first-word fall-through):
  - data_out = mem[rd_ptr], driven combinationally from storage.
  - valid_out = !empty.
  - A flit pushed at edge N is visible on data_out/valid_out after edge N. No same-cycle bypass from data_in.
- Occupancy:
  - count += push_accepted - pop_accepted.
  - full and empty are derived from count.
- Simultaneous push and pop:
  - When empty: the push is accepted and the pop is ignored. Result: count=1, valid_out=1 next cycle.
  - When full: both are accepted. count stays at DEPTH, and the new flit lands in the freed slot.
  - Otherwise: both are accepted and count is unchanged.
- Overflow:
  - A push while full with no pop is a credit-protocol violation.
  - The flit is dropped and storage is unchanged.
  - overflow_err is set and stays 1 until reset.
- Credit:
  - credit_out is registered. It is 1 for exactly the cycle after each accepted pop.
  - Back-to-back pops give back-to-back pulses.
  - Upstream holds DEPTH credits initially.
- Throughput: sustains one push and one pop per cycle indefinitely.

Decomposition:
- Shared router package holds:
  - direction one-hot constants (N/E/W/S/L, 5 bits);
  - DATASIZE, DEPTH and WIDTH defaults;
  - the flit field offsets (destination ID bits) consumed by route computation.
- One natural sub-module: ib_unicast_mem, a DEPTH x DATASIZE register array with one write port and one asynchronous read port.
- Pointer, count and credit logic stay in ib_unicast.

Test Plan:
- Reset, then push 0x0000_0A1 at edge 1 with rc_ready=0:
  - valid_out=1 and data_out=0x0000_0A1 after edge 1;
  - count=1, empty=0, credit_out=0.
- Fill with 0x1, 0x2, 0x3, 0x4:
  - full=1, count=4.
- Hold rc_ready=1 for 4 cycles after the fill:
  - data_out sequence 0x1, 0x2, 0x3, 0x4;
  - credit_out=1 on each of the 4 following cycles;
  - empty=1 at the end.
- While full, push 0x5 with no pop:
  - overflow_err=1 and count=4;
  - pops then return 0x1..0x4 only, and 0x5 never appears.
- While full, push 0x6 with rc_ready=1 in the same cycle:
  - count stays 4 and overflow_err stays 0;
  - the pop returns the old head, and 0x6 emerges after 0x2, 0x3, 0x4.
- Stream 10 flits 0x10..0x19 with valid_in=1 and rc_ready=1 continuously:
  - ordered output 0x10..0x19 with no gaps after the first;
  - pointers wrap without loss and count never exceeds 1.
- Assert rst mid-stream with count=3:
  - outputs go to reset values immediately, before the next clock edge;
  - no credit pulse follows;
  - after release, a push of 0x7 appears as the head.
